// File: rtl/player_motion_if.sv
// Bundle between the scan/button side and the player motion stage.
// The master drives scan position and raw buttons; the slave returns positions.
interface player_motion_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       btn_t1_up;
    logic       btn_t1_dn;
    logic       btn_t2_up;
    logic       btn_t2_dn;
    logic [9:0] team1_ver_pos;
    logic [9:0] team2_ver_pos;
    logic       frame_tick;

    modport master (
        output x,
        output y,
        output btn_t1_up,
        output btn_t1_dn,
        output btn_t2_up,
        output btn_t2_dn,
        input  team1_ver_pos,
        input  team2_ver_pos,
        input  frame_tick
    );

    modport slave (
        input  x,
        input  y,
        input  btn_t1_up,
        input  btn_t1_dn,
        input  btn_t2_up,
        input  btn_t2_dn,
        output team1_ver_pos,
        output team2_ver_pos,
        output frame_tick
    );
endinterface

// File: rtl/player_motion.sv
// Button-driven vertical motion for both players, updated once per frame
// during vertical blanking with a speed ramp and clamping to the active area.
module player_motion #(
    parameter int PLAYER_RADIUS   = 25,
    parameter int Y_ACT_MIN       = 35,
    parameter int Y_ACT_MAX       = 514,
    parameter int INIT_POS        = 275,
    parameter int UPDATE_LINE     = 515,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP_MIN        = 2,
    parameter int STEP_MAX        = 8,
    parameter int RAMP_FRAMES     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    player_motion_if.slave   io_pm
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_UP,
        S_DOWN
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STEP_MAX + 1) + 1;
    localparam int RW = $clog2(RAMP_FRAMES + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SPD_MIN  = SW'(STEP_MIN);
    localparam logic [SW-1:0] SPD_MAX  = SW'(STEP_MAX);
    localparam logic [RW-1:0] RUN_LAST = RW'(RAMP_FRAMES - 1);
    localparam logic [9:0]    POS_INIT = 10'(INIT_POS);
    localparam logic [9:0]    UPD_Y    = 10'(UPDATE_LINE);

    localparam logic signed [10:0] POS_LO = 11'(Y_ACT_MIN + PLAYER_RADIUS);
    localparam logic signed [10:0] POS_HI = 11'(Y_ACT_MAX - PLAYER_RADIUS);

    logic [3:0] w_raw;
    logic [3:0] w_btn;
    logic       w_tick;
    logic       r_tick;
    logic [9:0] w_pos [2];

    assign w_raw = {io_pm.btn_t2_dn, io_pm.btn_t2_up,
                    io_pm.btn_t1_dn, io_pm.btn_t1_up};

    assign w_tick = (io_pm.x == 10'd0) && (io_pm.y == UPD_Y);

    // Synchronise then debounce each raw button independently.
    for (genvar b = 0; b < 4; b++) begin : g_db
        logic          r_s1;
        logic          r_s2;
        logic          r_stb;
        logic [CW-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_stb <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[b];
                r_s2 <= r_s1;
                if (r_s2 == r_stb) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_stb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_btn[b] = r_stb;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
        state_t            r_state;
        state_t            w_state_nxt;
        state_t            w_dir;
        logic [SW-1:0]     r_speed;
        logic [SW-1:0]     w_speed_nxt;
        logic [SW-1:0]     w_spd_eff;
        logic [RW-1:0]     r_run;
        logic [RW-1:0]     w_run_nxt;
        logic [RW-1:0]     w_run_eff;
        logic [9:0]        r_pos;
        logic [9:0]        w_pos_nxt;
        logic              w_up;
        logic              w_dn;
        logic              w_entry;
        logic signed [10:0] w_base;
        logic signed [10:0] w_step;
        logic signed [10:0] w_sum;

        assign w_up = w_btn[2*p];
        assign w_dn = w_btn[2*p+1];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= S_HOLD;
                r_speed <= SPD_MIN;
                r_run   <= '0;
                r_pos   <= POS_INIT;
            end else begin
                r_state <= w_state_nxt;
                r_speed <= w_speed_nxt;
                r_run   <= w_run_nxt;
                r_pos   <= w_pos_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_speed_nxt = r_speed;
            w_run_nxt   = r_run;
            w_pos_nxt   = r_pos;
            w_dir       = S_HOLD;

            unique case (1'b1)
                (w_up && !w_dn): w_dir = S_UP;
                (w_dn && !w_up): w_dir = S_DOWN;
                default:         w_dir = S_HOLD;
            endcase

            // A fresh direction always restarts the ramp from the slowest step.
            w_entry   = (w_dir != r_state);
            w_spd_eff = w_entry ? SPD_MIN : r_speed;
            w_run_eff = w_entry ? '0 : r_run;
            w_base    = signed'(11'(r_pos));
            w_step    = signed'(11'(w_spd_eff));
            w_sum     = (w_dir == S_UP) ? (w_base - w_step)
                                        : (w_base + w_step);

            if (w_tick) begin
                w_state_nxt = w_dir;
                unique case (w_dir)
                    S_HOLD: begin
                        w_speed_nxt = SPD_MIN;
                        w_run_nxt   = '0;
                    end
                    S_UP, S_DOWN: begin
                        if (w_sum < POS_LO) begin
                            w_pos_nxt = POS_LO[9:0];
                        end else if (w_sum > POS_HI) begin
                            w_pos_nxt = POS_HI[9:0];
                        end else begin
                            w_pos_nxt = w_sum[9:0];
                        end
                        if (w_run_eff == RUN_LAST) begin
                            w_run_nxt   = '0;
                            w_speed_nxt = (w_spd_eff >= SPD_MAX)
                                        ? SPD_MAX : w_spd_eff + 1'b1;
                        end else begin
                            w_run_nxt   = w_run_eff + 1'b1;
                            w_speed_nxt = w_spd_eff;
                        end
                    end
                    default: begin
                        w_state_nxt = S_HOLD;
                    end
                endcase
            end
        end

        assign w_pos[p] = r_pos;
    end

    assign io_pm.team1_ver_pos = w_pos[0];
    assign io_pm.team2_ver_pos = w_pos[1];
    assign io_pm.frame_tick    = r_tick;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: ticks are forced by driving x/y
// directly so each frame is only a handful of clock cycles.
module tb_player_motion;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    player_motion_if pm_if ();

    player_motion #(
        .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_pm (pm_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic u1, input logic d1,
                           input logic u2, input logic d2);
        @(negedge clk);
        pm_if.btn_t1_up = u1;
        pm_if.btn_t1_dn = d1;
        pm_if.btn_t2_up = u2;
        pm_if.btn_t2_dn = d2;
        idle(12);
    endtask

    task automatic frame();
        idle(2);
        pm_if.x = 10'd0;
        pm_if.y = 10'd515;
        @(negedge clk);
        pm_if.x = 10'd1;
        pm_if.y = 10'd0;
        chk("tick_hi", int'(pm_if.frame_tick), 1);
        @(negedge clk);
        chk("tick_lo", int'(pm_if.frame_tick), 0);
    endtask

    task automatic no_tick(input int xv, input int yv);
        @(negedge clk);
        pm_if.x = 10'(xv);
        pm_if.y = 10'(yv);
        @(negedge clk);
        pm_if.x = 10'd1;
        pm_if.y = 10'd0;
        chk("no_tick", int'(pm_if.frame_tick), 0);
    endtask

    int t1_exp [20] = '{273, 271, 269, 267, 265, 263, 261, 259,
                        256, 253, 250, 247, 244, 241, 238, 235,
                        231, 227, 223, 219};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pm_if.x  = 10'd1;
        pm_if.y  = 10'd0;
        pm_if.btn_t1_up = 1'b0;
        pm_if.btn_t1_dn = 1'b0;
        pm_if.btn_t2_up = 1'b0;
        pm_if.btn_t2_dn = 1'b0;

        idle(3);
        chk("rst_t1", int'(pm_if.team1_ver_pos), 275);
        chk("rst_t2", int'(pm_if.team2_ver_pos), 275);
        chk("rst_tick", int'(pm_if.frame_tick), 0);
        rst_n = 1'b1;

        for (int f = 0; f < 3; f++) begin
            frame();
            chk("idle_t1", int'(pm_if.team1_ver_pos), 275);
            chk("idle_t2", int'(pm_if.team2_ver_pos), 275);
        end

        no_tick(1, 515);
        no_tick(0, 514);
        no_tick(0, 516);

        set_btn(1, 0, 0, 0);
        for (int f = 0; f < 20; f++) begin
            frame();
            chk($sformatf("ramp_t1_f%0d", f + 1),
                int'(pm_if.team1_ver_pos), t1_exp[f]);
        end
        chk("ramp_t2", int'(pm_if.team2_ver_pos), 275);
        set_btn(0, 0, 0, 0);
        frame();

        @(negedge clk);
        pm_if.btn_t1_up = 1'b1;
        @(negedge clk);
        pm_if.x = 10'd0;
        pm_if.y = 10'd515;
        @(negedge clk);
        pm_if.x = 10'd1;
        pm_if.y = 10'd0;
        @(negedge clk);
        pm_if.btn_t1_up = 1'b0;
        idle(12);
        frame();
        chk("glitch_t1", int'(pm_if.team1_ver_pos), 219);

        set_btn(1, 1, 0, 0);
        for (int f = 0; f < 5; f++) frame();
        chk("both_t1", int'(pm_if.team1_ver_pos), 219);
        set_btn(1, 0, 0, 0);
        frame();
        chk("both_then_up", int'(pm_if.team1_ver_pos), 217);
        set_btn(0, 0, 0, 0);
        frame();

        set_btn(0, 0, 0, 1);
        for (int f = 1; f <= 200; f++) begin
            frame();
            if (f == 8)   chk("dn_f8",   int'(pm_if.team2_ver_pos), 291);
            if (f == 16)  chk("dn_f16",  int'(pm_if.team2_ver_pos), 315);
            if (f == 46)  chk("dn_f46",  int'(pm_if.team2_ver_pos), 477);
            if (f == 47)  chk("dn_f47",  int'(pm_if.team2_ver_pos), 484);
            if (f == 48)  chk("dn_f48",  int'(pm_if.team2_ver_pos), 489);
            if (f == 200) chk("dn_f200", int'(pm_if.team2_ver_pos), 489);
        end
        chk("dn_t1", int'(pm_if.team1_ver_pos), 217);
        set_btn(0, 0, 0, 0);
        frame();

        set_btn(1, 0, 0, 0);
        for (int f = 1; f <= 45; f++) begin
            frame();
            if (f == 32) chk("up_f32", int'(pm_if.team1_ver_pos), 105);
            if (f == 39) chk("up_f39", int'(pm_if.team1_ver_pos), 63);
            if (f == 40) chk("up_f40", int'(pm_if.team1_ver_pos), 60);
            if (f == 45) chk("up_f45", int'(pm_if.team1_ver_pos), 60);
        end
        set_btn(0, 0, 0, 0);
        frame();

        set_btn(1, 0, 0, 0);
        for (int f = 0; f < 18; f++) frame();
        @(negedge clk);
        rst_n   = 1'b0;
        pm_if.x = 10'd0;
        pm_if.y = 10'd515;
        @(negedge clk);
        chk("mrst_t1", int'(pm_if.team1_ver_pos), 275);
        chk("mrst_t2", int'(pm_if.team2_ver_pos), 275);
        chk("mrst_tick", int'(pm_if.frame_tick), 0);
        rst_n   = 1'b1;
        pm_if.x = 10'd1;
        pm_if.y = 10'd0;
        idle(12);
        for (int f = 1; f <= 10; f++) begin
            frame();
            if (f == 1)  chk("post_f1",  int'(pm_if.team1_ver_pos), 273);
            if (f == 10) chk("post_f10", int'(pm_if.team1_ver_pos), 253);
        end
        set_btn(0, 1, 0, 0);
        frame();
        chk("reverse_t1", int'(pm_if.team1_ver_pos), 255);
        chk("reverse_t2", int'(pm_if.team2_ver_pos), 275);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
